// File: rtl/set_assoc_cache_pkg.sv
// Shared types and constants for the set-associative data cache.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        READ_MEM,
        WRITE_MEM,
        RESPOND
    } cache_state_t;

    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_SET_WIDTH  = 3;
    localparam int DEF_WAYS       = 2;

    // A binary tree over WAYS leaves has WAYS-1 internal nodes.
    function automatic int plru_bits(input int ways);
        return (ways > 1) ? ways - 1 : 1;
    endfunction

endpackage

// File: rtl/set_assoc_cache_plru_tree.sv
// Combinational tree pseudo-LRU: victim selection and touch update for one set.
module plru_tree
    import cache_pkg::*;
#(
    parameter int WAYS = DEF_WAYS
) (
    input  logic [WAYS-2:0]         tree_i,
    input  logic [$clog2(WAYS)-1:0] touch_way_i,
    input  logic                    touch_en_i,
    output logic [WAYS-2:0]         tree_o,
    output logic [$clog2(WAYS)-1:0] victim_o
);
    localparam int WAY_W = $clog2(WAYS);

    // Heap-ordered nodes: node n has children 2n+1 (left) and 2n+2 (right).
    logic [WAY_W-1:0] vnode;
    logic [WAY_W-1:0] tnode;

    always_comb begin
        vnode    = '0;
        victim_o = '0;
        for (int l = 0; l < WAY_W; l++) begin
            victim_o[WAY_W-1-l] = tree_i[vnode];
            vnode = WAY_W'(2 * int'(vnode) + 1 + int'(tree_i[vnode]));
        end
    end

    // Each node on the touched path is pointed at the sibling subtree.
    always_comb begin
        tree_o = tree_i;
        tnode  = '0;
        if (touch_en_i) begin
            for (int l = 0; l < WAY_W; l++) begin
                tree_o[tnode] = ~touch_way_i[WAY_W-1-l];
                tnode = WAY_W'(2 * int'(tnode) + 1 + int'(touch_way_i[WAY_W-1-l]));
            end
        end
    end

endmodule

// File: rtl/set_assoc_cache.sv
// N-way write-through, no-write-allocate data cache with tree PLRU and a memory handshake.
// Optional hit/miss counters are enabled by defining CACHE_STATS_EN.
module set_assoc_cache
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int SET_WIDTH  = DEF_SET_WIDTH,
    parameter int WAYS       = DEF_WAYS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid_i,
    input  logic                  req_write_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  ready_o,
    output logic                  hit_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    input  logic                  mem_ack_i
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]           hit_count_o,
    output logic [31:0]           miss_count_o
`endif
);
    localparam int TAG_WIDTH = ADDR_WIDTH - SET_WIDTH - 2;
    localparam int SETS      = 1 << SET_WIDTH;
    localparam int WAY_W     = $clog2(WAYS);
    localparam int PLRU_W    = plru_bits(WAYS);

    logic [WAYS-1:0]       valid_q [SETS];
    logic [WAYS-1:0]       valid_d [SETS];
    logic [PLRU_W-1:0]     plru_q  [SETS];
    logic [PLRU_W-1:0]     plru_d  [SETS];
    logic [TAG_WIDTH-1:0]  tag_q   [SETS][WAYS];
    logic [DATA_WIDTH-1:0] data_q  [SETS][WAYS];

    cache_state_t          state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  write_q, write_d;

    logic [ADDR_WIDTH-1:0] lk_addr;
    logic [SET_WIDTH-1:0]  lk_set;
    logic [TAG_WIDTH-1:0]  lk_tag;
    logic                  hit;
    logic [WAY_W-1:0]      hit_way;
    logic [WAY_W-1:0]      fill_way;
    logic [WAY_W-1:0]      plru_victim;
    logic [PLRU_W-1:0]     plru_next;
    logic                  touch_en;
    logic [WAY_W-1:0]      touch_way;
    logic                  arr_we;
    logic [WAY_W-1:0]      arr_way;
    logic [DATA_WIDTH-1:0] arr_data;
    logic                  unused_addr_lsb;

    // While a miss is outstanding the lookup follows the latched address.
    assign lk_addr         = (state_q == IDLE) ? addr_i : addr_q;
    assign lk_set          = lk_addr[SET_WIDTH+1:2];
    assign lk_tag          = lk_addr[ADDR_WIDTH-1:SET_WIDTH+2];
    assign unused_addr_lsb = ^lk_addr[1:0];

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[lk_set][w] && (tag_q[lk_set][w] == lk_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Empty ways are filled lowest index first before PLRU takes over.
    always_comb begin
        fill_way = plru_victim;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[lk_set][w]) begin
                fill_way = WAY_W'(w);
            end
        end
    end

    plru_tree #(
        .WAYS(WAYS)
    ) u_plru (
        .tree_i      (plru_q[lk_set]),
        .touch_way_i (touch_way),
        .touch_en_i  (touch_en),
        .tree_o      (plru_next),
        .victim_o    (plru_victim)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        write_d   = write_q;
        valid_d   = valid_q;
        plru_d    = plru_q;
        touch_en  = 1'b0;
        touch_way = hit_way;
        arr_we    = 1'b0;
        arr_way   = hit_way;
        arr_data  = wdata_i;
        ready_o   = 1'b0;
        hit_o     = 1'b0;
        rdata_o   = '0;
        mem_req_o = 1'b0;
        mem_we_o  = 1'b0;

        case (state_q)
            IDLE: begin
                hit_o = req_valid_i && hit;
                if (req_valid_i) begin
                    if (req_write_i) begin
                        addr_d  = addr_i;
                        wdata_d = wdata_i;
                        write_d = 1'b1;
                        state_d = WRITE_MEM;
                        if (hit) begin
                            arr_we   = 1'b1;
                            touch_en = 1'b1;
                        end
                    end else if (hit) begin
                        ready_o  = 1'b1;
                        rdata_o  = data_q[lk_set][hit_way];
                        touch_en = 1'b1;
                    end else begin
                        addr_d  = addr_i;
                        write_d = 1'b0;
                        state_d = READ_MEM;
                    end
                end
            end
            READ_MEM: begin
                mem_req_o = 1'b1;
                if (mem_ack_i) begin
                    touch_en                 = 1'b1;
                    touch_way                = fill_way;
                    arr_we                   = 1'b1;
                    arr_way                  = fill_way;
                    arr_data                 = mem_rdata_i;
                    valid_d[lk_set][fill_way] = 1'b1;
                    rdata_d                  = mem_rdata_i;
                    state_d                  = RESPOND;
                end
            end
            WRITE_MEM: begin
                mem_req_o = 1'b1;
                mem_we_o  = 1'b1;
                if (mem_ack_i) begin
                    state_d = RESPOND;
                end
            end
            RESPOND: begin
                ready_o = 1'b1;
                if (!write_q) begin
                    rdata_o = rdata_q;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (touch_en) begin
            plru_d[lk_set] = plru_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            write_q <= 1'b0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            write_q <= write_d;
            valid_q <= valid_d;
            plru_q  <= plru_d;
        end
    end

    // Tag/data contents are meaningless until the matching valid bit is set.
    always_ff @(posedge clk) begin
        if (arr_we && !rst) begin
            tag_q[lk_set][arr_way]  <= lk_tag;
            data_q[lk_set][arr_way] <= arr_data;
        end
    end

    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;

`ifdef CACHE_STATS_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if ((state_q == IDLE) && req_valid_i) begin
            if (hit) begin
                if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 32'd1;
            end else begin
                if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_count_o  = hit_cnt_q;
    assign miss_count_o = miss_cnt_q;
`endif

endmodule
